pgm_sound_mailbox: RTL and testbench

Parametrised 68k-to-Z80 sound command mailbox: replaces the single-register sound latches with CHANNELS independent per-channel FIFOs (host→sound), optional per-channel reply registers (sound→host), sticky overflow flags and a maskable Z80 interrupt. It sits between the 68k address decode (C00000 latch region) and the Z80 I/O decode (ports 81xx/82xx/84xx). Both sides present single-cycle strobes already synchronised to the 68k clock domain.

---
 rtl/pgm_sound_mailbox.sv | 146 ++++++++++++++
 tb/tb_pgm_sound_mailbox.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pgm_sound_mailbox.sv
// 68k-to-Z80 sound command mailbox: per-channel FIFOs, sticky overflow, maskable IRQ.
// Optional sound-to-host reply registers are built when MAILBOX_REPLY_EN is defined.
module pgm_sound_mailbox #(
  parameter int CHANNELS = 3,
  parameter int DEPTH    = 4,
  parameter int DW       = 8,
  localparam int CW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                fixed_20m_clk,
  input  logic                reset_n,
  input  logic                m_wr,
  input  logic                m_rd,
  input  logic [CW-1:0]       m_ch,
  input  logic [DW-1:0]       m_din,
  output logic [DW-1:0]       m_dout,
  output logic [CHANNELS-1:0] m_full,
  output logic [CHANNELS-1:0] m_reply_valid,
  output logic [CHANNELS-1:0] overflow,
  input  logic [CHANNELS-1:0] ovf_clr,
  input  logic                z_rd,
  input  logic                z_wr,
  input  logic [CW-1:0]       z_ch,
  input  logic [DW-1:0]       z_din,
  output logic [DW-1:0]       z_dout,
  output logic [CHANNELS-1:0] z_empty,
  input  logic [CHANNELS-1:0] irq_mask,
  output logic                z_int_n
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [DW-1:0] mem  [CHANNELS][DEPTH];
  logic [AW-1:0] wptr [CHANNELS];
  logic [AW-1:0] rptr [CHANNELS];
  logic [AW:0]   cnt  [CHANNELS];

  logic [CHANNELS-1:0] push_req;
  logic [CHANNELS-1:0] pop_req;
  logic [CHANNELS-1:0] push_ok;
  logic [CHANNELS-1:0] pop_ok;
  logic [CHANNELS-1:0] ovf_set;
  logic [CHANNELS-1:0] full;
  logic [CHANNELS-1:0] empty;

  // A pop frees the slot a same-cycle push on a full channel needs.
  always_comb begin
    push_req = '0;
    pop_req  = '0;
    push_ok  = '0;
    pop_ok   = '0;
    ovf_set  = '0;
    full     = '0;
    empty    = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      full[i]     = (cnt[i] == CNT_FULL);
      empty[i]    = (cnt[i] == '0);
      push_req[i] = m_wr && (m_ch == CW'(i));
      pop_req[i]  = z_rd && (z_ch == CW'(i));
      pop_ok[i]   = pop_req[i] && !empty[i];
      push_ok[i]  = push_req[i] && (!full[i] || pop_ok[i]);
      ovf_set[i]  = push_req[i] && full[i] && !pop_ok[i];
    end
  end

  always_ff @(posedge fixed_20m_clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        wptr[i] <= '0;
        rptr[i] <= '0;
        cnt[i]  <= '0;
      end
      overflow <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (push_ok[i]) wptr[i] <= wptr[i] + 1'b1;
        if (pop_ok[i])  rptr[i] <= rptr[i] + 1'b1;
        if (push_ok[i] && !pop_ok[i])
          cnt[i] <= cnt[i] + 1'b1;
        else if (!push_ok[i] && pop_ok[i])
          cnt[i] <= cnt[i] - 1'b1;
      end
      overflow <= (overflow & ~ovf_clr) | ovf_set;
    end
  end

  always_ff @(posedge fixed_20m_clk) begin
    for (int i = 0; i < CHANNELS; i++)
      if (push_ok[i]) mem[i][wptr[i]] <= m_din;
  end

  assign z_empty = empty;
  assign m_full  = full;

  always_comb begin
    z_dout = '1;
    for (int i = 0; i < CHANNELS; i++)
      if (z_ch == CW'(i) && !empty[i])
        z_dout = mem[i][rptr[i]];
  end

  always_ff @(posedge fixed_20m_clk or negedge reset_n) begin
    if (!reset_n)
      z_int_n <= 1'b1;
    else
      z_int_n <= ~|(~empty & irq_mask);
  end

`ifdef MAILBOX_REPLY_EN
  logic [DW-1:0]       reply [CHANNELS];
  logic [CHANNELS-1:0] rvalid;

  // A reply write beats a same-cycle host read, so the fresh data stays pending.
  always_ff @(posedge fixed_20m_clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < CHANNELS; i++)
        reply[i] <= '1;
      rvalid <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (z_wr && z_ch == CW'(i)) begin
          reply[i]  <= z_din;
          rvalid[i] <= 1'b1;
        end else if (m_rd && m_ch == CW'(i)) begin
          rvalid[i] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    m_dout = '1;
    for (int i = 0; i < CHANNELS; i++)
      if (m_ch == CW'(i))
        m_dout = reply[i];
  end

  assign m_reply_valid = rvalid;
`else
  logic unused_reply;
  assign unused_reply  = ^{z_wr, m_rd, z_din};
  assign m_dout        = '1;
  assign m_reply_valid = '0;
`endif

endmodule

// File: tb/tb_pgm_sound_mailbox.sv
// Directed bench for pgm_sound_mailbox (CHANNELS=3, DEPTH=4, DW=8).
// Reply expectations follow MAILBOX_REPLY_EN the same way the design build does.
module tb_pgm_sound_mailbox;

  logic       clk;
  logic       reset_n;
  logic       m_wr;
  logic       m_rd;
  logic [1:0] m_ch;
  logic [7:0] m_din;
  logic [7:0] m_dout;
  logic [2:0] m_full;
  logic [2:0] m_reply_valid;
  logic [2:0] overflow;
  logic [2:0] ovf_clr;
  logic       z_rd;
  logic       z_wr;
  logic [1:0] z_ch;
  logic [7:0] z_din;
  logic [7:0] z_dout;
  logic [2:0] z_empty;
  logic [2:0] irq_mask;
  logic       z_int_n;

  int checks = 0;
  int errors = 0;

  pgm_sound_mailbox #(
    .CHANNELS(3),
    .DEPTH(4),
    .DW(8)
  ) dut (
    .fixed_20m_clk(clk),
    .reset_n(reset_n),
    .m_wr(m_wr),
    .m_rd(m_rd),
    .m_ch(m_ch),
    .m_din(m_din),
    .m_dout(m_dout),
    .m_full(m_full),
    .m_reply_valid(m_reply_valid),
    .overflow(overflow),
    .ovf_clr(ovf_clr),
    .z_rd(z_rd),
    .z_wr(z_wr),
    .z_ch(z_ch),
    .z_din(z_din),
    .z_dout(z_dout),
    .z_empty(z_empty),
    .irq_mask(irq_mask),
    .z_int_n(z_int_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] ch, input logic [7:0] d);
    m_wr = 1'b1; m_ch = ch; m_din = d;
    tick();
    m_wr = 1'b0;
  endtask

  task automatic pop(input logic [1:0] ch);
    z_rd = 1'b1; z_ch = ch;
    tick();
    z_rd = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    m_wr = 0; m_rd = 0; m_ch = 0; m_din = 0;
    z_rd = 0; z_wr = 0; z_ch = 0; z_din = 0;
    ovf_clr = 0; irq_mask = 0;
    tick(); tick();
    check("rst_empty", z_empty, 3'b111);
    check("rst_full", m_full, 3'b000);
    check("rst_ovf", overflow, 3'b000);
    check("rst_int", z_int_n, 1'b1);
    check("rst_rvalid", m_reply_valid, 3'b000);
    check("rst_mdout", m_dout, 8'hFF);
    check("rst_zdout", z_dout, 8'hFF);
    reset_n = 1'b1;
    tick();

    // basic push/pop on ch1
    push(2'd1, 8'h11);
    push(2'd1, 8'h22);
    z_ch = 2'd1; #1;
    check("t1_empty", z_empty, 3'b101);
    check("t1_head0", z_dout, 8'h11);
    pop(2'd1);
    check("t1_head1", z_dout, 8'h22);
    pop(2'd1);
    check("t1_empty2", z_empty, 3'b111);
    check("t1_dout_ff", z_dout, 8'hFF);

    // overflow on ch0
    for (int k = 0; k < 5; k++) begin
      push(2'd0, 8'hA0 + 8'(k));
      if (k == 3) check("t2_full4", m_full, 3'b001);
    end
    check("t2_ovf", overflow, 3'b001);
    check("t2_full", m_full, 3'b001);
    for (int k = 0; k < 4; k++) begin
      z_ch = 2'd0; #1;
      check("t2_pop", z_dout, 8'hA0 + 8'(k));
      pop(2'd0);
    end
    check("t2_drained", z_empty, 3'b111);
    check("t2_ovf_hold", overflow, 3'b001);
    ovf_clr = 3'b001;
    tick();
    ovf_clr = 3'b000;
    check("t2_ovf_clr", overflow, 3'b000);

    // full ch2 with simultaneous push and pop
    for (int k = 0; k < 4; k++) push(2'd2, 8'h30 + 8'(k));
    m_wr = 1; m_ch = 2; m_din = 8'h55; z_rd = 1; z_ch = 2;
    tick();
    m_wr = 0; z_rd = 0;
    check("t3_full", m_full, 3'b100);
    check("t3_ovf", overflow, 3'b000);
    check("t3_head", z_dout, 8'h31);
    pop(2'd2);
    check("t3_h32", z_dout, 8'h32);
    pop(2'd2);
    check("t3_h33", z_dout, 8'h33);
    pop(2'd2);
    check("t3_h55", z_dout, 8'h55);
    pop(2'd2);
    check("t3_empty", z_empty, 3'b111);
    pop(2'd2);
    check("t3_pop_empty", z_empty, 3'b111);
    check("t3_pop_empty_ovf", overflow, 3'b000);
    m_wr = 1; m_ch = 2; m_din = 8'h66; z_rd = 1; z_ch = 2;
    tick();
    m_wr = 0; z_rd = 0;
    check("t3_pp_empty", z_empty, 3'b011);
    check("t3_pp_head", z_dout, 8'h66);
    pop(2'd2);

    // interrupt masking and latency
    irq_mask = 3'b010;
    push(2'd0, 8'h01);
    tick();
    check("t4_masked", z_int_n, 1'b1);
    push(2'd1, 8'h02);
    check("t4_edgeN", z_int_n, 1'b1);
    tick();
    check("t4_edgeN1", z_int_n, 1'b0);
    pop(2'd1);
    check("t4_pop_N", z_int_n, 1'b0);
    tick();
    check("t4_pop_N1", z_int_n, 1'b1);
    irq_mask = 3'b001;
    tick();
    check("t4_mask_on", z_int_n, 1'b0);
    irq_mask = 3'b000;
    tick();
    check("t4_mask_off", z_int_n, 1'b1);
    pop(2'd0);

    // reply path
    z_wr = 1; z_ch = 2; z_din = 8'h7E;
    tick();
    z_wr = 0;
    m_ch = 2; #1;
`ifdef MAILBOX_REPLY_EN
    check("t5_valid", m_reply_valid, 3'b100);
    check("t5_data", m_dout, 8'h7E);
    z_wr = 1; z_ch = 2; z_din = 8'h7F; m_rd = 1; m_ch = 2;
    tick();
    z_wr = 0; m_rd = 0;
    check("t5_both_valid", m_reply_valid, 3'b100);
    check("t5_both_data", m_dout, 8'h7F);
    m_rd = 1;
    tick();
    m_rd = 0;
    check("t5_consumed", m_reply_valid, 3'b000);
    check("t5_keep", m_dout, 8'h7F);
`else
    check("t5_valid", m_reply_valid, 3'b000);
    check("t5_data", m_dout, 8'hFF);
`endif

    // out-of-range channel
    push(2'd3, 8'h99);
    z_rd = 1; z_ch = 2'd3;
    tick();
    z_rd = 0;
    check("t6_empty", z_empty, 3'b111);
    check("t6_full", m_full, 3'b000);
    check("t6_ovf", overflow, 3'b000);
    check("t6_zdout", z_dout, 8'hFF);
    m_ch = 2'd3; #1;
    check("t6_mdout", m_dout, 8'hFF);

    // async reset mid-fill
    irq_mask = 3'b011;
    push(2'd0, 8'hC0);
    for (int k = 0; k < 5; k++) push(2'd1, 8'hD0 + 8'(k));
    z_wr = 1; z_ch = 2'd0; z_din = 8'h12;
    tick();
    z_wr = 0;
    check("t7_pre_int", z_int_n, 1'b0);
    check("t7_pre_ovf", overflow, 3'b010);
    #2;
    reset_n = 1'b0;
    #1;
    check("t7_empty", z_empty, 3'b111);
    check("t7_full", m_full, 3'b000);
    check("t7_ovf", overflow, 3'b000);
    check("t7_int", z_int_n, 1'b1);
    check("t7_rvalid", m_reply_valid, 3'b000);
    m_ch = 2'd0; #1;
    check("t7_mdout", m_dout, 8'hFF);
    tick();
    reset_n = 1'b1;
    tick();
    push(2'd1, 8'hE1);
    z_ch = 2'd1; #1;
    check("t7_ptr_reset", z_dout, 8'hE1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
